// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle: Moore control unit for one round of the Experiment 4
// memory-matching game. It clears the datapath, waits for a player move,
// registers the keys, checks the comparator and advances the address. The
// round ends on a full 16-entry match, a mismatch or a move timeout.
//
// Ports:
//   clock               system clock, rising edge
//   reset               asynchronous, active-low
//   iniciar             start a round (honoured in INICIAL and the FIM states)
//   jogada              player move level; only its rising edge matters
//   chavesIgualMemoria  comparator equality from the datapath
//   fimC                counter terminal count from the datapath
//   zeraC, zeraR        datapath counter / key register clear
//   contaC              counter increment enable
//   registraR           key register load enable
//   pronto              round finished
//   acertou/errou/timeout  mutually exclusive result flags
//   db_estado           current state code
module exp4_unidade_controle #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARA     = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARA     = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_TIMEOUT = 4'b1101,
    FIM_ERRO    = 4'b1110,
    FIM_ACERTO  = 4'b1111
  } estado_t;

  estado_t         estado;
  estado_t         prox;
  logic            jogada_d;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_prox;
  logic            jog_edge;
  logic            expirou;

  // A held jogada yields a single edge since jogada_d follows it every cycle.
  assign jog_edge = jogada & ~jogada_d;
  assign expirou  = (timer == TW'(TIMEOUT - 1));

  // Next-state logic; a move edge wins over a same-cycle timer expiry.
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:  prox = iniciar ? PREPARA : INICIAL;
      PREPARA:  prox = ESPERA;
      ESPERA: begin
        if (jog_edge)     prox = REGISTRA;
        else if (expirou) prox = FIM_TIMEOUT;
        else              prox = ESPERA;
      end
      REGISTRA: prox = COMPARA;
      COMPARA: begin
        if (!chavesIgualMemoria) prox = FIM_ERRO;
        else if (fimC)           prox = FIM_ACERTO;
        else                     prox = PROXIMO;
      end
      PROXIMO:  prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        prox = iniciar ? PREPARA : estado;
      default:  prox = INICIAL;
    endcase
  end

  // Timer only counts while remaining in ESPERA; it never reaches TIMEOUT.
  always_comb begin
    timer_prox = '0;
    if (estado == ESPERA && prox == ESPERA) timer_prox = timer + TW'(1);
  end

  // State, edge register, timer and outputs. Outputs are decoded from the
  // next state so the registered flags line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      jogada_d  <= 1'b0;
      timer     <= '0;
      zeraC     <= 1'b0;
      zeraR     <= 1'b0;
      contaC    <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado    <= prox;
      jogada_d  <= jogada;
      timer     <= timer_prox;
      zeraC     <= (prox == PREPARA);
      zeraR     <= (prox == PREPARA);
      contaC    <= (prox == PROXIMO);
      registraR <= (prox == REGISTRA);
      pronto    <= (prox == FIM_ACERTO) || (prox == FIM_ERRO) ||
                   (prox == FIM_TIMEOUT);
      acertou   <= (prox == FIM_ACERTO);
      errou     <= (prox == FIM_ERRO);
      timeout   <= (prox == FIM_TIMEOUT);
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// tb_exp4_unidade_controle: directed self-checking bench for the Exp4 control
// unit. Main instance uses TIMEOUT=8; a second instance with a long timeout
// shares the inputs and is used where a move sequence outlasts 8 cycles.
module tb_exp4_unidade_controle;

  localparam int unsigned TO = 8;

  // {db_estado, zeraC, zeraR, contaC, registraR, pronto, acertou, errou, timeout}
  localparam logic [11:0] E_INI  = 12'h000;
  localparam logic [11:0] E_PREP = 12'h1C0;
  localparam logic [11:0] E_ESP  = 12'h200;
  localparam logic [11:0] E_REG  = 12'h410;
  localparam logic [11:0] E_COMP = 12'h500;
  localparam logic [11:0] E_PROX = 12'h620;
  localparam logic [11:0] E_ACE  = 12'hF0C;
  localparam logic [11:0] E_ERR  = 12'hE0A;
  localparam logic [11:0] E_TO   = 12'hD09;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, chaves, fim_c;

  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic zeraC_l, contaC_l, zeraR_l, registraR_l, pronto_l, acertou_l, errou_l, timeout_l;
  logic [3:0] db_estado_l;
  logic [11:0] obs, obs_l;

  int checks = 0;
  int passed = 0;
  int n_reg = 0, n_reg_l = 0, n_conta = 0, run_c = 0, max_run_c = 0;

  exp4_unidade_controle #(.TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chaves), .fimC(fim_c),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  exp4_unidade_controle #(.TIMEOUT(5000)) u_long (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chaves), .fimC(fim_c),
    .zeraC(zeraC_l), .contaC(contaC_l), .zeraR(zeraR_l), .registraR(registraR_l),
    .pronto(pronto_l), .acertou(acertou_l), .errou(errou_l), .timeout(timeout_l),
    .db_estado(db_estado_l)
  );

  assign obs   = {db_estado, zeraC, zeraR, contaC, registraR, pronto, acertou, errou, timeout};
  assign obs_l = {db_estado_l, zeraC_l, zeraR_l, contaC_l, registraR_l,
                  pronto_l, acertou_l, errou_l, timeout_l};

  always #5 clock = ~clock;

  // Pulse counters and contaC width tracking, sampled mid-cycle.
  always @(negedge clock) begin
    if (registraR) n_reg++;
    if (registraR_l) n_reg_l++;
    if (contaC) begin
      n_conta++;
      run_c++;
      if (run_c > max_run_c) max_run_c = run_c;
    end else begin
      run_c = 0;
    end
  end

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; chaves = 1'b0; fim_c = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++; if (obs !== E_INI) $display("FAIL reset_hold: got %h expected %h", obs, E_INI); else passed++;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      checks++; if (obs !== E_INI) $display("FAIL idle: got %h expected %h", obs, E_INI); else passed++;
    end
  endtask

  task automatic start();
    iniciar = 1'b1;
    @(negedge clock);
    checks++; if (obs !== E_PREP) $display("FAIL start_prepara: got %h expected %h", obs, E_PREP); else passed++;
    iniciar = 1'b0;
    @(negedge clock);
    checks++; if (obs !== E_ESP) $display("FAIL start_espera: got %h expected %h", obs, E_ESP); else passed++;
  endtask

  // One move from ESPERA; exp_after is the state seen after COMPARA.
  task automatic move(input logic eq, input logic fim, input logic [11:0] exp_after);
    chaves = eq; fim_c = fim; jogada = 1'b1;
    @(negedge clock);
    checks++; if (obs !== E_REG) $display("FAIL move_registra: got %h expected %h", obs, E_REG); else passed++;
    jogada = 1'b0;
    @(negedge clock);
    checks++; if (obs !== E_COMP) $display("FAIL move_compara: got %h expected %h", obs, E_COMP); else passed++;
    @(negedge clock);
    checks++; if (obs !== exp_after) $display("FAIL move_result: got %h expected %h", obs, exp_after); else passed++;
    if (exp_after == E_PROX) begin
      @(negedge clock);
      checks++; if (obs !== E_ESP) $display("FAIL move_back_espera: got %h expected %h", obs, E_ESP); else passed++;
    end
  endtask

  task automatic test_success();
    int b_r, b_c;
    start();
    b_r = n_reg; b_c = n_conta;
    for (int i = 0; i < 16; i++) move(1'b1, (i == 15), (i == 15) ? E_ACE : E_PROX);
    checks++; if (n_conta - b_c != 15) $display("FAIL success_conta_pulses: got %0d expected 15", n_conta - b_c); else passed++;
    checks++; if (n_reg - b_r != 16) $display("FAIL success_registra_pulses: got %0d expected 16", n_reg - b_r); else passed++;
    checks++; if (max_run_c != 1) $display("FAIL conta_width: got %0d expected 1", max_run_c); else passed++;
  endtask

  task automatic test_error();
    int b_c;
    start();
    b_c = n_conta;
    move(1'b1, 1'b0, E_PROX);
    move(1'b1, 1'b0, E_PROX);
    move(1'b0, 1'b0, E_ERR);
    checks++; if (n_conta - b_c != 2) $display("FAIL error_conta_pulses: got %0d expected 2", n_conta - b_c); else passed++;
  endtask

  task automatic test_timeout();
    start();
    repeat (TO - 1) begin
      @(negedge clock);
      checks++; if (obs !== E_ESP) $display("FAIL timeout_wait: got %h expected %h", obs, E_ESP); else passed++;
    end
    @(negedge clock);
    checks++; if (obs !== E_TO) $display("FAIL timeout_at_limit: got %h expected %h", obs, E_TO); else passed++;
    // Move edge arriving in the last ESPERA cycle beats the expiry.
    start();
    repeat (TO - 1) @(negedge clock);
    chaves = 1'b0; fim_c = 1'b0; jogada = 1'b1;
    @(negedge clock);
    checks++; if (obs !== E_REG) $display("FAIL move_beats_timeout: got %h expected %h", obs, E_REG); else passed++;
    jogada = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (obs !== E_ERR) $display("FAIL late_move_error: got %h expected %h", obs, E_ERR); else passed++;
  endtask

  task automatic test_held_jogada();
    int b_r, b_rl;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    start();
    checks++; if (obs_l !== E_ESP) $display("FAIL held_long_espera: got %h expected %h", obs_l, E_ESP); else passed++;
    b_r = n_reg; b_rl = n_reg_l;
    chaves = 1'b1; fim_c = 1'b0; jogada = 1'b1;
    @(negedge clock);
    checks++; if (obs_l !== E_REG) $display("FAIL held_registra: got %h expected %h", obs_l, E_REG); else passed++;
    repeat (9) @(negedge clock);
    checks++; if (obs_l !== E_ESP) $display("FAIL held_mid_espera: got %h expected %h", obs_l, E_ESP); else passed++;
    repeat (10) @(negedge clock);
    checks++; if (obs_l !== E_ESP) $display("FAIL held_end_espera: got %h expected %h", obs_l, E_ESP); else passed++;
    checks++; if (n_reg_l - b_rl != 1) $display("FAIL held_registra_long: got %0d expected 1", n_reg_l - b_rl); else passed++;
    checks++; if (n_reg - b_r != 1) $display("FAIL held_registra_main: got %0d expected 1", n_reg - b_r); else passed++;
    checks++; if (obs !== E_TO) $display("FAIL held_main_timeout: got %h expected %h", obs, E_TO); else passed++;
    jogada = 1'b0;
  endtask

  task automatic test_midround_reset();
    start();
    jogada = 1'b1;
    @(negedge clock);
    checks++; if (obs !== E_REG) $display("FAIL pre_reset_registra: got %h expected %h", obs, E_REG); else passed++;
    jogada = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (obs !== E_INI) $display("FAIL async_reset: got %h expected %h", obs, E_INI); else passed++;
    checks++; if (obs_l !== E_INI) $display("FAIL async_reset_long: got %h expected %h", obs_l, E_INI); else passed++;
    @(negedge clock);
    checks++; if (obs !== E_INI) $display("FAIL reset_held_idle: got %h expected %h", obs, E_INI); else passed++;
    reset = 1'b1;
    start();
    move(1'b0, 1'b0, E_ERR);
    iniciar = 1'b1;
    @(negedge clock);
    checks++; if (obs !== E_PREP) $display("FAIL restart_prepara: got %h expected %h", obs, E_PREP); else passed++;
    iniciar = 1'b0;
    @(negedge clock);
    checks++; if (obs !== E_ESP) $display("FAIL restart_zera_one_cycle: got %h expected %h", obs, E_ESP); else passed++;
  endtask

  initial begin
    test_reset();
    test_success();
    test_error();
    test_timeout();
    test_held_jogada();
    test_midround_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
